// File: rtl/tdm_pkg.sv
// Shared definitions for the 16-slot TDM demux and its 16:1 mux counterpart.
//
// Contents:
//   TDM_SLOTS    - number of data slots per frame (16)
//   FRAME_SLOTS  - slots per frame on the wire (16, or 17 with the trailing parity slot)
//   SLOT_W       - width of the slot index (4, or 5 with parity)
//   LAST_SLOT    - index of the final slot of a frame
//   tdm_state_e  - framing state {HUNT, LOCKED}
//   even_par()   - even-parity bit over one frame of data slots
//
// Optional feature: define TDM_DEMUX_PARITY_EN to add the trailing parity slot.
package tdm_pkg;

    localparam int unsigned TDM_SLOTS = 16;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned FRAME_SLOTS = TDM_SLOTS + 1;
`else
    localparam int unsigned FRAME_SLOTS = TDM_SLOTS;
`endif

    localparam int unsigned SLOT_W = $clog2(FRAME_SLOTS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_SLOTS - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    typedef logic [SLOT_W-1:0] slot_t;

    // Bit that makes the total number of ones (data + parity) even.
    function automatic logic even_par(input logic [TDM_SLOTS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/tdm_demux_16_if.sv
// Bus bundle between a serial TDM source and the 16-slot demux.
//
// Signals:
//   din          - serial sample, one slot per accepted beat     (source -> demux)
//   din_valid    - qualifies din and frame_sync                  (source -> demux)
//   frame_sync   - marks slot 0 of a frame                       (source -> demux)
//   dout         - last complete frame, dout[k] is slot k        (demux -> sink)
//   frame_valid  - one-cycle pulse when dout updates             (demux -> sink)
//   locked       - demux is frame-locked                         (demux -> sink)
//   sync_err     - one-cycle pulse on a framing violation        (demux -> sink)
//   par_err      - one-cycle pulse on a parity mismatch          (demux -> sink)
//
// Modports: master (source/sink side), slave (demux side).
interface tdm_demux_16_if
    import tdm_pkg::*;
();

    logic                 din;
    logic                 din_valid;
    logic                 frame_sync;
    logic [TDM_SLOTS-1:0] dout;
    logic                 frame_valid;
    logic                 locked;
    logic                 sync_err;
    logic                 par_err;

    modport master (
        output din,
        output din_valid,
        output frame_sync,
        input  dout,
        input  frame_valid,
        input  locked,
        input  sync_err,
        input  par_err
    );

    modport slave (
        input  din,
        input  din_valid,
        input  frame_sync,
        output dout,
        output frame_valid,
        output locked,
        output sync_err,
        output par_err
    );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demux.
//
// Ports:
//   clk_i    - clock
//   rst_ni   - synchronous active-low reset (counter -> 0)
//   clr_i    - force the counter to 0 (highest priority)
//   load1_i  - force the counter to 1 (a beat was taken as slot 0)
//   en_i     - advance by one, wrapping from Last to 0
//   slot_o   - current slot index
module tdm_slot_ctr #(
    parameter int unsigned       Width = 4,
    parameter logic [Width-1:0]  Last  = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load1_i,
    input  logic             en_i,
    output logic [Width-1:0] slot_o
);

    logic [Width-1:0] slot_d, slot_q;

    always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
            slot_d = '0;
        end else if (load1_i) begin
            slot_d = Width'(1);
        end else if (en_i) begin
            slot_d = (slot_q == Last) ? '0 : slot_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux_16.sv
// 16-slot serial TDM demultiplexer with frame-sync tracking.
//
// Collects one serial bit per accepted beat into a shadow register and publishes the
// whole frame on dout when its last slot arrives. A two-state framer (HUNT/LOCKED)
// follows frame_sync; SYNC_LOSS_LIMIT consecutive frames without a sync mark on slot 0
// drop lock.
//
// Ports:
//   clk    - clock, all state updates on its rising edge
//   rst_n  - synchronous active-low reset
//   bus    - tdm_demux_16_if.slave (din, din_valid, frame_sync in;
//            dout, frame_valid, locked, sync_err, par_err out)
//
// Optional feature: TDM_DEMUX_PARITY_EN adds a 17th slot carrying even parity over
// slots 0-15; a mismatch pulses par_err and suppresses publication. Without it par_err
// is tied low.
module tdm_demux_16
    import tdm_pkg::*;
#(
    parameter int unsigned SYNC_LOSS_LIMIT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux_16_if.slave bus
);

    // Miss counter only has to hold 0 .. SYNC_LOSS_LIMIT-1.
    localparam int unsigned MissW = (SYNC_LOSS_LIMIT > 1) ? $clog2(SYNC_LOSS_LIMIT) : 1;

    tdm_state_e state_q, state_d;
    logic [MissW-1:0] miss_q, miss_d;

    logic [TDM_SLOTS-1:0] shadow_q, shadow_d;
    logic [TDM_SLOTS-1:0] dout_q, dout_d;
    logic frame_valid_q, frame_valid_d;
    logic sync_err_q, sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
    logic par_err_q, par_err_d;
`endif

    slot_t slot_q;
    logic  ctr_clr, ctr_load1, ctr_en;

    logic beat, fs, din;
    logic slot_is0, miss_at_limit;

    assign beat          = bus.din_valid;
    assign fs            = bus.frame_sync;
    assign din           = bus.din;
    assign slot_is0      = (slot_q == '0);
    assign miss_at_limit = (miss_q == MissW'(SYNC_LOSS_LIMIT - 1));

    tdm_slot_ctr #(
        .Width (SLOT_W),
        .Last  (LAST_SLOT)
    ) u_slot_ctr (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (ctr_clr),
        .load1_i (ctr_load1),
        .en_i    (ctr_en),
        .slot_o  (slot_q)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    // FSM next state and miss counter.
    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        if (beat) begin
            unique case (state_q)
                HUNT: begin
                    if (fs) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (fs) begin
                        // Any sync mark, aligned or not, proves the source is framing.
                        miss_d = '0;
                    end else if (slot_is0) begin
                        if (miss_at_limit) begin
                            state_d = HUNT;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MissW'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // FSM outputs: slot counter control, shadow capture and frame publication.
    always_comb begin
        shadow_d      = shadow_q;
        dout_d        = dout_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        par_err_d     = 1'b0;
`endif
        ctr_clr       = 1'b0;
        ctr_load1     = 1'b0;
        ctr_en        = 1'b0;
        if (beat) begin
            unique case (state_q)
                HUNT: begin
                    if (fs) begin
                        shadow_d    = '0;
                        shadow_d[0] = din;
                        ctr_load1   = 1'b1;
                    end
                end
                LOCKED: begin
                    if (fs && !slot_is0) begin
                        // Early sync: drop the partial frame and restart on this beat.
                        // Also covers sync on the final slot, so that frame is never published.
                        sync_err_d  = 1'b1;
                        shadow_d    = '0;
                        shadow_d[0] = din;
                        ctr_load1   = 1'b1;
                    end else if (!fs && slot_is0) begin
                        sync_err_d = 1'b1;
                        if (miss_at_limit) begin
                            ctr_clr = 1'b1;
                        end else begin
                            shadow_d[0] = din;
                            ctr_load1   = 1'b1;
                        end
                    end else begin
                        ctr_en = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                        if (!slot_q[SLOT_W-1]) begin
                            shadow_d[slot_q[SLOT_W-2:0]] = din;
                        end
                        if (slot_q == LAST_SLOT) begin
                            // din is the parity slot here; shadow_q already holds all data.
                            if (din == even_par(shadow_q)) begin
                                dout_d        = shadow_q;
                                frame_valid_d = 1'b1;
                            end else begin
                                par_err_d = 1'b1;
                            end
                        end
`else
                        shadow_d[slot_q] = din;
                        if (slot_q == LAST_SLOT) begin
                            dout_d        = shadow_d;
                            frame_valid_d = 1'b1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q     <= 1'b0;
`endif
        end else begin
            shadow_q      <= shadow_d;
            dout_q        <= dout_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q     <= par_err_d;
`endif
        end
    end

    assign bus.dout        = dout_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.sync_err    = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign bus.par_err     = par_err_q;
`else
    assign bus.par_err     = 1'b0;
`endif

endmodule
